cmd_decider: RTL and testbench

CMD_DECIDER -- requirements
Module: cmd_decider

---
 rtl/cmd_decider.sv | 205 ++++++++++++++++++++
 tb/tb_cmd_decider.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_decider.sv
// Command decider: sequences capture -> per-channel DTW -> argmin -> reject test.
// Optional macro CONFIDENCE_MARGIN_EN: accept only if min + MARGIN < noise score.
module cmd_decider #(
    parameter int unsigned  N_CH        = 9,
    parameter int unsigned  SCORE_W     = 26,
    parameter int unsigned  TIMEOUT_CYC = 2**20,
    parameter int unsigned  MARGIN      = 0,
    localparam int unsigned CH_W        = $clog2(N_CH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    talk,
    output logic                    feat_start,
    input  logic                    feat_done,
    input  logic                    train_en,
    input  logic [CH_W-1:0]         train_sel,
    output logic [N_CH-1:0]         dtw_start,
    output logic [N_CH-1:0]         dtw_train,
    input  logic [N_CH-1:0]         dtw_done,
    input  logic [N_CH*SCORE_W-1:0] dtw_score,
    output logic [CH_W-1:0]         cmd,
    output logic                    cmd_valid,
    output logic                    timeout,
    output logic                    busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [CH_W-1:0]  CH_FIRST = CH_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

`ifdef CONFIDENCE_MARGIN_EN
    localparam logic [SCORE_W:0] MARGIN_EFF = (SCORE_W+1)'(MARGIN);
`else
    localparam logic [SCORE_W:0] MARGIN_EFF = (SCORE_W+1)'(MARGIN) & '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECORD,
        S_RUN,
        S_SCAN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                feat_start_q, feat_start_d;
    logic [N_CH-1:0]     dtw_start_q, dtw_start_d;
    logic [N_CH-1:0]     dtw_train_q, dtw_train_d;
    logic [CH_W-1:0]     cmd_q, cmd_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic [N_CH-1:0]     done_seen_q, done_seen_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                train_q, train_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic [CH_W-1:0]     scan_ch_q, scan_ch_d;
    logic [SCORE_W-1:0]  min_q, min_d;
    logic [CH_W-1:0]     idx_q, idx_d;

    logic [SCORE_W-1:0]  score_a [N_CH];
    logic                sel_ok_c;
    logic                run_exit_c;
    logic                accept_c;

    // Unpack the flat score bus into one entry per channel
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_score
        assign score_a[gi] = dtw_score[gi*SCORE_W +: SCORE_W];
    end

    assign sel_ok_c   = (32'(train_sel) < N_CH);
    assign run_exit_c = train_q ? done_seen_q[sel_q] : (&done_seen_q);
    assign accept_c   = (({1'b0, min_q} + MARGIN_EFF) < {1'b0, score_a[0]});

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            feat_start_q <= 1'b0;
            dtw_start_q  <= '0;
            dtw_train_q  <= '0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_seen_q  <= '0;
            cnt_q        <= '0;
            train_q      <= 1'b0;
            sel_q        <= '0;
            scan_ch_q    <= '0;
            min_q        <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            feat_start_q <= feat_start_d;
            dtw_start_q  <= dtw_start_d;
            dtw_train_q  <= dtw_train_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_seen_q  <= done_seen_d;
            cnt_q        <= cnt_d;
            train_q      <= train_d;
            sel_q        <= sel_d;
            scan_ch_q    <= scan_ch_d;
            min_q        <= min_d;
            idx_q        <= idx_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        feat_start_d = 1'b0;
        dtw_start_d  = '0;
        dtw_train_d  = dtw_train_q;
        cmd_d        = '0;
        cmd_valid_d  = 1'b0;
        timeout_d    = 1'b0;
        done_seen_d  = done_seen_q;
        cnt_d        = cnt_q;
        train_d      = train_q;
        sel_d        = sel_q;
        scan_ch_d    = scan_ch_q;
        min_d        = min_q;
        idx_d        = idx_q;

        case (state_q)
            S_IDLE: begin
                if (talk) begin
                    state_d      = S_RECORD;
                    feat_start_d = 1'b1;
                end
            end
            S_RECORD: begin
                if (feat_done) begin
                    done_seen_d = '0;
                    cnt_d       = '0;
                    train_d     = train_en;
                    sel_d       = train_sel;
                    if (!train_en) begin
                        state_d     = S_RUN;
                        dtw_start_d = '1;
                    end else if (sel_ok_c) begin
                        state_d     = S_RUN;
                        dtw_start_d = N_CH'(1) << train_sel;
                        dtw_train_d = dtw_train_q | (N_CH'(1) << train_sel);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                done_seen_d = done_seen_q | dtw_done;
                cnt_d       = cnt_q + CNT_W'(1);
                // Timeout pulse is pre-decoded so it lines up with the final RUN cycle
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    dtw_train_d = '0;
                end else if (run_exit_c) begin
                    state_d     = train_q ? S_IDLE : S_SCAN;
                    scan_ch_d   = CH_FIRST;
                    dtw_train_d = '0;
                end else if (cnt_q == CNT_PRE) begin
                    timeout_d = 1'b1;
                end
            end
            S_SCAN: begin
                // First channel seeds the minimum; strict < keeps the lower index on ties
                if ((scan_ch_q == CH_FIRST) || (score_a[scan_ch_q] < min_q)) begin
                    min_d = score_a[scan_ch_q];
                    idx_d = scan_ch_q;
                end
                if (scan_ch_q == CH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    scan_ch_d = scan_ch_q + CH_W'(1);
                end
            end
            S_DONE: begin
                cmd_d       = accept_c ? idx_q : '0;
                cmd_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                dtw_train_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign feat_start = feat_start_q;
    assign dtw_start  = dtw_start_q;
    assign dtw_train  = dtw_train_q;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cmd_decider.sv
// Directed bench for cmd_decider: recognition, reject, margin, training, timeout, reset abort.
module tb_cmd_decider;

    localparam int unsigned N    = 9;
    localparam int unsigned SW   = 26;
    localparam int unsigned CW   = 4;
    localparam int unsigned TOUT = 64;

    logic            clock = 1'b0;
    logic            reset;
    logic            talk;
    logic            feat_start;
    logic            feat_done;
    logic            train_en;
    logic [CW-1:0]   train_sel;
    logic [N-1:0]    dtw_start;
    logic [N-1:0]    dtw_train;
    logic [N-1:0]    dtw_done;
    logic [N*SW-1:0] dtw_score;
    logic [CW-1:0]   cmd;
    logic            cmd_valid;
    logic            timeout;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;
    int cv_cnt = 0;
    int to_cnt = 0;
    int unsigned sc [N];
    int lat, c, k, cv0, to0;

    cmd_decider #(
        .N_CH       (N),
        .SCORE_W    (SW),
        .TIMEOUT_CYC(TOUT),
        .MARGIN     (100)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .talk      (talk),
        .feat_start(feat_start),
        .feat_done (feat_done),
        .train_en  (train_en),
        .train_sel (train_sel),
        .dtw_start (dtw_start),
        .dtw_train (dtw_train),
        .dtw_done  (dtw_done),
        .dtw_score (dtw_score),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Pulse counters used to prove single / absent pulses
    always @(posedge clock) begin
        if (cmd_valid) cv_cnt <= cv_cnt + 1;
        if (timeout)   to_cnt <= to_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pack;
        for (int i = 0; i < int'(N); i++) dtw_score[i*SW +: SW] = SW'(sc[i]);
    endtask

    // Recognition pass with all done bits at once; returns latency and cmd at cmd_valid
    task automatic recog(output int l, output int cc);
        talk = 1'b1; tick(1); talk = 1'b0; tick(1);
        train_en = 1'b0; feat_done = 1'b1; tick(1); feat_done = 1'b0; tick(1);
        dtw_done = '1;
        l = 0;
        do begin
            tick(1); l++; dtw_done = '0;
        end while (!cmd_valid && l < 40);
        cc = 32'(cmd);
        tick(1);
    endtask

    initial begin
        reset = 1'b1; talk = 1'b0; feat_done = 1'b0; train_en = 1'b0;
        train_sel = '0; dtw_done = '0; dtw_score = '0;
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_feat_start", 32'(feat_start), 0);
        chk("rst_dtw_start", 32'(dtw_start), 0);
        chk("rst_dtw_train", 32'(dtw_train), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b0; tick(1);

        // Recognition with staggered done bits: min 400 at ch2 (tie with ch4) beats noise 500
        sc = '{500, 900, 400, 700, 400, 800, 900, 950, 990}; pack();
        talk = 1'b1; tick(1);
        chk("talk_feat_start", 32'(feat_start), 1);
        chk("talk_busy", 32'(busy), 1);
        talk = 1'b0; tick(1);
        chk("feat_start_pulse", 32'(feat_start), 0);
        feat_done = 1'b1; tick(1);
        chk("recog_start_all", 32'(dtw_start), 32'h1FF);
        chk("recog_no_train", 32'(dtw_train), 0);
        feat_done = 1'b0; tick(1);
        chk("recog_start_pulse", 32'(dtw_start), 0);
        dtw_done = 9'h003; tick(1);
        dtw_done = 9'h07C; tick(1);
        dtw_done = '0; tick(2);
        chk("recog_wait_busy", 32'(busy), 1);
        cv0 = cv_cnt;
        dtw_done = 9'h180;
        lat = 0;
        do begin
            tick(1); lat++; dtw_done = '0;
        end while (!cmd_valid && lat < 40);
        chk("recog_latency", 32'(lat), 11);
        chk("recog_cmd", 32'(cmd), 2);
        tick(1);
        chk("cmd_valid_pulse", 32'(cmd_valid), 0);
        chk("cmd_clear", 32'(cmd), 0);
        chk("cmd_valid_once", 32'(cv_cnt - cv0), 1);

        // Reject: no channel strictly below noise (ch3 equals it)
        sc = '{500, 600, 600, 500, 600, 900, 700, 800, 600}; pack();
        recog(lat, c);
        chk("reject_latency", 32'(lat), 11);
        chk("reject_cmd", 32'(c), 0);

        // Margin 100: 450 + 100 is not below 500 when the margin feature is built in
        sc = '{500, 900, 450, 900, 900, 900, 900, 900, 900}; pack();
        recog(lat, c);
`ifdef CONFIDENCE_MARGIN_EN
        chk("margin_cmd", 32'(c), 0);
`else
        chk("margin_cmd", 32'(c), 2);
`endif

        // Unsigned compare (ch1 all ones) and last channel wins
        sc = '{200, 32'h3FFFFFF, 900, 900, 900, 900, 900, 900, 100}; pack();
        recog(lat, c);
        chk("last_ch_cmd", 32'(c), 8);

        // Tie between ch5 and ch7 keeps ch5
        sc = '{500, 900, 900, 900, 900, 300, 900, 300, 900}; pack();
        recog(lat, c);
        chk("tie_cmd", 32'(c), 5);

        // Training on ch5; inputs changed after the transition must not matter
        cv0 = cv_cnt;
        train_en = 1'b1; train_sel = 4'd5;
        talk = 1'b1; tick(1); talk = 1'b0; tick(1);
        feat_done = 1'b1; tick(1);
        chk("train_start", 32'(dtw_start), 32'h020);
        chk("train_flag", 32'(dtw_train), 32'h020);
        feat_done = 1'b0; train_en = 1'b0; train_sel = 4'd0; tick(1);
        chk("train_start_pulse", 32'(dtw_start), 0);
        chk("train_flag_held", 32'(dtw_train), 32'h020);
        dtw_done = 9'h008; tick(1); dtw_done = '0; tick(1);
        chk("train_other_done", 32'(busy), 1);
        dtw_done = 9'h020; tick(1); dtw_done = '0;
        chk("train_capture", 32'(busy), 1);
        tick(1);
        chk("train_exit_busy", 32'(busy), 0);
        chk("train_exit_flag", 32'(dtw_train), 0);
        tick(3);
        chk("train_no_cmd_valid", 32'(cv_cnt - cv0), 0);

        // Out-of-range training channel goes straight back to IDLE
        train_en = 1'b1; train_sel = 4'd12;
        talk = 1'b1; tick(1); talk = 1'b0; tick(1);
        feat_done = 1'b1; tick(1);
        chk("badsel_busy", 32'(busy), 0);
        chk("badsel_start", 32'(dtw_start), 0);
        feat_done = 1'b0; train_en = 1'b0; train_sel = 4'd0;
        tick(2);
        chk("badsel_no_cmd_valid", 32'(cv_cnt - cv0), 0);

        // Timeout: ch7 never completes
        cv0 = cv_cnt; to0 = to_cnt;
        talk = 1'b1; tick(1); talk = 1'b0; tick(1);
        feat_done = 1'b1; tick(1); feat_done = 1'b0;
        dtw_done = 9'h17F;
        k = 1;
        while (!timeout && k < 200) begin
            tick(1); dtw_done = '0; k++;
        end
        chk("timeout_cycle", 32'(k), 64);
        chk("timeout_busy_held", 32'(busy), 1);
        tick(1);
        chk("timeout_pulse", 32'(timeout), 0);
        chk("timeout_busy_fall", 32'(busy), 0);
        chk("timeout_once", 32'(to_cnt - to0), 1);
        chk("timeout_no_cmd_valid", 32'(cv_cnt - cv0), 0);

        // Reset during SCAN cycle 3 aborts without cmd_valid
        talk = 1'b1; tick(1); talk = 1'b0; tick(1);
        feat_done = 1'b1; tick(1); feat_done = 1'b0;
        dtw_done = '1; tick(1); dtw_done = '0;
        tick(3);
        chk("scan3_busy", 32'(busy), 1);
        cv0 = cv_cnt; to0 = to_cnt;
        reset = 1'b1; tick(1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cmd", 32'(cmd), 0);
        chk("abort_cmd_valid", 32'(cmd_valid), 0);
        chk("abort_train", 32'(dtw_train), 0);
        chk("abort_start", 32'(dtw_start), 0);
        reset = 1'b0;
        tick(20);
        chk("abort_no_cmd_valid", 32'(cv_cnt - cv0), 0);
        chk("abort_no_timeout", 32'(to_cnt - to0), 0);
        recog(lat, c);
        chk("restart_latency", 32'(lat), 11);
        chk("restart_cmd", 32'(c), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
